// File: rtl/circ_shift_pkg.sv
// Shared definitions for the circular shift register family.
//   loader_state_t : FSM encoding used by circular_shift_loader.
//   DEF_WIDTH      : default bits per entry.
//   DEF_SIZE       : default number of entries.
package circ_shift_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SIZE  = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROTATE
    } loader_state_t;

endpackage

// File: rtl/circ_rotate_array.sv
// SIZE x WIDTH register array with four mutually prioritised operations.
//   clk, rst_n  : clock, asynchronous active-low reset (clears every entry).
//   clr_all     : zero every entry.
//   load_first  : zero every entry except entry 0, which takes wr_data.
//   wr_en       : write wr_data into entry wr_idx, others hold.
//   rot_en      : rotate by one, entry i takes entry i-1, entry 0 takes the last.
//   data        : all entries in parallel.
// Priority: clr_all > load_first > wr_en > rot_en.
module circ_rotate_array #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_all,
    input  logic                     load_first,
    input  logic                     wr_en,
    input  logic [$clog2(SIZE)-1:0]  wr_idx,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rot_en,
    output logic [WIDTH-1:0]         data [SIZE-1:0]
);

    // NOTE: this storage is reset on purpose: the block must present an
    // all-zero array immediately on reset, so it cannot map to a RAM macro.
    // NOTE: sequential state is assigned with <= so every entry samples the
    // pre-edge values; with = the rotation would smear one value across all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) data[i] <= '0;
        end else if (clr_all) begin
            for (int i = 0; i < SIZE; i++) data[i] <= '0;
        end else if (load_first) begin
            for (int i = 1; i < SIZE; i++) data[i] <= '0;
            data[0] <= wr_data;
        end else if (wr_en) begin
            data[wr_idx] <= wr_data;
        end else if (rot_en) begin
            data[0] <= data[SIZE-1];
            for (int i = 1; i < SIZE; i++) data[i] <= data[i-1];
        end
    end

endmodule

// File: rtl/circular_shift_loader.sv
// Loads a message over a valid/ready stream into a SIZE-entry array, then
// rotates the array on demand for a scrolling display.
//   clk, rst_n  : clock, asynchronous active-low reset.
//   clear       : synchronous return to IDLE with an all-zero array.
//   in_data     : word to load.
//   in_valid    : in_data valid this cycle.
//   in_last     : final word of the message (sampled on handshake).
//   in_ready    : a word can be accepted this cycle.
//   shift_en    : rotate one position (ROTATE state only).
//   reg_out     : all entries in parallel.
//   load_count  : words held from the current/last load.
//   loaded      : high in ROTATE.
module circular_shift_loader
    import circ_shift_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SIZE  = DEF_SIZE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    input  logic                       shift_en,
    output logic [WIDTH-1:0]           reg_out [SIZE-1:0],
    output logic [$clog2(SIZE+1)-1:0]  load_count,
    output logic                       loaded
);

    localparam int CW = $clog2(SIZE + 1);
    localparam int IW = $clog2(SIZE);

    loader_state_t state;
    logic          accept;
    logic          hit_full;

    // Ready depends only on registered state and clear, never on in_valid,
    // so an upstream source may wait for ready before raising valid.
    assign in_ready = ((state == IDLE) || (state == LOAD)) && !clear;
    assign accept   = in_valid && in_ready;
    assign loaded   = (state == ROTATE);
    // The word being accepted in LOAD fills the last free entry.
    assign hit_full = ((load_count + CW'(1)) == CW'(SIZE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            load_count <= '0;
        end else if (clear) begin
            state      <= IDLE;
            load_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        load_count <= CW'(1);
                        state      <= in_last ? ROTATE : LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        load_count <= load_count + CW'(1);
                        if (in_last || hit_full) state <= ROTATE;
                    end
                end
                ROTATE: ;  // leaves only through clear or reset
                default: state <= IDLE;
            endcase
        end
    end

    // load_count never reaches SIZE while in LOAD, so truncation is safe.
    circ_rotate_array #(
        .WIDTH (WIDTH),
        .SIZE  (SIZE)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_all    (clear),
        .load_first (accept && (state == IDLE)),
        .wr_en      (accept && (state == LOAD)),
        .wr_idx     (load_count[IW-1:0]),
        .wr_data    (in_data),
        .rot_en     (shift_en && (state == ROTATE)),
        .data       (reg_out)
    );

endmodule

// File: tb/tb_circular_shift_loader.sv
// Randomised self-checking bench for circular_shift_loader. The reference
// keeps the accepted message as a queue plus a rotation offset and derives
// each expected entry from those.
module tb_circular_shift_loader;

    localparam int WIDTH = 8;
    localparam int SIZE  = 16;
    localparam int CW    = $clog2(SIZE + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clear;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             shift_en;
    logic [WIDTH-1:0] reg_out [SIZE-1:0];
    logic [CW-1:0]    load_count;
    logic             loaded;

    int total = 0;
    int bad   = 0;

    // Reference: message words, rotation offset, message-complete flag.
    logic [WIDTH-1:0] msg [$];
    int               off;
    bit               done;

    circular_shift_loader #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .shift_en   (shift_en),
        .reg_out    (reg_out),
        .load_count (load_count),
        .loaded     (loaded)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] exp_entry(input int i);
        int k;
        k = (i - off + SIZE) % SIZE;
        return (k < msg.size()) ? msg[k] : '0;
    endfunction

    function automatic logic exp_ready();
        return !done && !clear;
    endfunction

    task automatic model_reset();
        msg.delete();
        off  = 0;
        done = 1'b0;
    endtask

    task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit l,
                         input bit s, input bit c);
        in_valid = v; in_data = d; in_last = l; shift_en = s; clear = c;
    endtask

    // Advance one clock edge; the reference sees the same inputs the DUT does.
    task automatic edge_step();
        bit rdy;
        rdy = exp_ready();
        @(posedge clk);
        if (clear) begin
            model_reset();
        end else if (in_valid && rdy) begin
            msg.push_back(in_data);
            done = in_last || (msg.size() == SIZE);
        end else if (done && shift_en) begin
            off = (off + 1) % SIZE;
        end
        #1;
    endtask

    task automatic tick(input bit v, input logic [WIDTH-1:0] d, input bit l,
                        input bit s, input bit c);
        drive(v, d, l, s, c);
        edge_step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, '0, 0, 0, 0);
        model_reset();
        #2;
        for (int i = 0; i < SIZE; i++) begin
            total++;
            if (reg_out[i] !== '0) begin
                bad++; $display("FAIL reset_entry[%0d]: got %0h expected 0", i, reg_out[i]);
            end
        end
        total++;
        if (load_count !== '0 || loaded !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ctrl: count=%0d loaded=%0b ready=%0b expected 0/0/1",
                            load_count, loaded, in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        tick(1, 8'h11, 0, 0, 0);
        tick(1, 8'h22, 0, 0, 0);
        drive(0, '0, 0, 0, 0);
        total++;
        if (reg_out[0] !== 8'h11 || reg_out[1] !== 8'h22 || load_count !== CW'(2)) begin
            bad++; $display("FAIL pre_reset_load: got %0h %0h cnt=%0d expected 11 22 cnt=2",
                            reg_out[0], reg_out[1], load_count);
        end
        // Drop reset between edges: outputs must change with no clock.
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < SIZE; i++) begin
            total++;
            if (reg_out[i] !== '0) begin
                bad++; $display("FAIL midreset_entry[%0d]: got %0h expected 0", i, reg_out[i]);
            end
        end
        total++;
        if (load_count !== '0 || loaded !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL midreset_ctrl: count=%0d loaded=%0b ready=%0b expected 0/0/1",
                            load_count, loaded, in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_short();
        tick(1, 8'hA0, 0, 0, 0);
        tick(1, 8'hA1, 0, 0, 0);
        tick(1, 8'hA2, 1, 0, 0);
        drive(0, '0, 0, 0, 0);
        #1;
        for (int i = 0; i < SIZE; i++) begin
            total++;
            if (reg_out[i] !== exp_entry(i)) begin
                bad++; $display("FAIL short_entry[%0d]: got %0h expected %0h", i, reg_out[i], exp_entry(i));
            end
        end
        total++;
        if (load_count !== CW'(3) || loaded !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL short_ctrl: count=%0d loaded=%0b ready=%0b expected 3/1/0",
                            load_count, loaded, in_ready);
        end
        // Words offered in ROTATE must be ignored.
        for (int c = 0; c < 5; c++) begin
            tick(1, 8'h55, 0, 0, 0);
            total++;
            if (reg_out[3] !== 8'h00 || reg_out[0] !== 8'hA0 || load_count !== CW'(3)) begin
                bad++; $display("FAIL ignored_word cycle %0d: got e0=%0h e3=%0h cnt=%0d expected A0 00 3",
                                c, reg_out[0], reg_out[3], load_count);
            end
        end
        tick(0, '0, 0, 0, 1);
    endtask

    task automatic test_full_and_rotate();
        int pulses;
        int cycles;
        for (int w = 0; w < SIZE; w++) tick(1, WIDTH'(w), 0, 0, 0);
        drive(1, 8'h99, 0, 0, 0);
        #1;
        total++;
        if (loaded !== 1'b1 || in_ready !== 1'b0 || load_count !== CW'(SIZE)) begin
            bad++; $display("FAIL full_ctrl: loaded=%0b ready=%0b cnt=%0d expected 1/0/%0d",
                            loaded, in_ready, load_count, SIZE);
        end
        edge_step();  // 17th word offered
        for (int i = 0; i < SIZE; i++) begin
            total++;
            if (reg_out[i] !== WIDTH'(i)) begin
                bad++; $display("FAIL full_entry[%0d]: got %0h expected %0h", i, reg_out[i], i);
            end
        end
        tick(0, '0, 0, 1, 0);
        total++;
        if (reg_out[0] !== 8'h0F || reg_out[1] !== 8'h00 || load_count !== CW'(SIZE)) begin
            bad++; $display("FAIL rotate_one: got %0h %0h cnt=%0d expected 0f 00 %0d",
                            reg_out[0], reg_out[1], load_count, SIZE);
        end
        pulses = 1;
        cycles = 0;
        while (pulses < SIZE && cycles < 200) begin
            bit s;
            s = 1'($urandom_range(0, 1));
            tick(0, '0, 0, s, 0);
            if (s) pulses++;
            cycles++;
            for (int i = 0; i < SIZE; i++) begin
                total++;
                if (reg_out[i] !== exp_entry(i)) begin
                    bad++; $display("FAIL rotate_entry[%0d] pulse %0d: got %0h expected %0h",
                                    i, pulses, reg_out[i], exp_entry(i));
                end
            end
        end
        total++;
        if (pulses != SIZE) begin
            bad++; $display("FAIL rotate_budget: got %0d pulses expected %0d", pulses, SIZE);
        end
        for (int i = 0; i < SIZE; i++) begin
            total++;
            if (reg_out[i] !== WIDTH'(i)) begin
                bad++; $display("FAIL rotate_wrap[%0d]: got %0h expected %0h", i, reg_out[i], i);
            end
        end
        tick(0, '0, 0, 0, 1);
    endtask

    task automatic test_shift_in_load_and_clear();
        tick(1, 8'h31, 0, 0, 0);
        tick(1, 8'h32, 0, 0, 0);
        for (int c = 0; c < 3; c++) tick(0, '0, 0, 1, 0);
        total++;
        if (reg_out[0] !== 8'h31 || reg_out[1] !== 8'h32 || reg_out[SIZE-1] !== 8'h00) begin
            bad++; $display("FAIL shift_in_load: got %0h %0h %0h expected 31 32 00",
                            reg_out[0], reg_out[1], reg_out[SIZE-1]);
        end
        drive(1, 8'h77, 0, 1, 1);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL clear_ready: got %0b expected 0", in_ready);
        end
        edge_step();
        drive(0, '0, 0, 0, 0);
        #1;
        for (int i = 0; i < SIZE; i++) begin
            total++;
            if (reg_out[i] !== '0) begin
                bad++; $display("FAIL clear_entry[%0d]: got %0h expected 0", i, reg_out[i]);
            end
        end
        total++;
        if (load_count !== '0 || loaded !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL clear_ctrl: cnt=%0d loaded=%0b ready=%0b expected 0/0/1",
                            load_count, loaded, in_ready);
        end
    endtask

    task automatic test_valid_gaps();
        int acc;
        int cycles;
        acc = 0;
        cycles = 0;
        while (acc < 4 && cycles < 200) begin
            bit v;
            v = 1'($urandom_range(0, 1));
            tick(v, WIDTH'($urandom), (acc == 3), 0, 0);
            if (v) acc++;
            cycles++;
            total++;
            if (load_count !== CW'(msg.size())) begin
                bad++; $display("FAIL gap_count: got %0d expected %0d", load_count, msg.size());
            end
            for (int i = 0; i < SIZE; i++) begin
                total++;
                if (reg_out[i] !== exp_entry(i)) begin
                    bad++; $display("FAIL gap_entry[%0d]: got %0h expected %0h", i, reg_out[i], exp_entry(i));
                end
            end
        end
        total++;
        if (acc != 4 || loaded !== 1'b1) begin
            bad++; $display("FAIL gap_done: accepted=%0d loaded=%0b expected 4/1", acc, loaded);
        end
        tick(0, '0, 0, 0, 1);
    endtask

    // Mixed random traffic: messages of random length, random shifts and clears.
    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            drive(1'($urandom_range(0, 1)), WIDTH'($urandom), (r < 8),
                  1'($urandom_range(0, 1)), (r >= 97));
            #1;
            total++;
            if (in_ready !== exp_ready()) begin
                bad++; $display("FAIL rand_ready cycle %0d: got %0b expected %0b", c, in_ready, exp_ready());
            end
            edge_step();
            total++;
            if (load_count !== CW'(msg.size()) || loaded !== done) begin
                bad++; $display("FAIL rand_ctrl cycle %0d: cnt=%0d loaded=%0b expected %0d/%0b",
                                c, load_count, loaded, msg.size(), done);
            end
            for (int i = 0; i < SIZE; i++) begin
                total++;
                if (reg_out[i] !== exp_entry(i)) begin
                    bad++; $display("FAIL rand_entry[%0d] cycle %0d: got %0h expected %0h",
                                    i, c, reg_out[i], exp_entry(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_short();
        test_full_and_rotate();
        test_shift_in_load_and_clear();
        test_valid_gaps();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
